// File: rtl/alaw_pcm_serializer.sv
// alaw_pcm_serializer
//
// Downstream stage of the A-law coder. Codes arrive over a valid/ready
// handshake, wait in a small FIFO, receive the G.711 even-bit inversion and
// leave MSB-first on a framed serial PCM line whose bit clock and frame sync
// are generated here from the system clock.
//
// Ports:
//   clk, rst_n      system clock (rising edge) and asynchronous active-low reset
//   in_alaw[7:0]    A-law code {sign, seg[2:0], mant[3:0]}
//   in_valid        in_alaw is valid this cycle
//   in_ready        FIFO can accept a code (not full)
//   en              serializer run request, sampled at frame boundaries
//   clr_underrun    single-cycle pulse clearing the underrun flag
//   pcm_sclk        serial bit clock (high for the first half of each bit)
//   pcm_fsync       frame sync, high for the whole of bit 0
//   pcm_dout        serial data, changes on the sclk rising edge
//   underrun        sticky: a frame started while the FIFO was empty
//   fifo_level      current FIFO occupancy
module alaw_pcm_serializer #(
  parameter int CLK_DIV     = 4,
  parameter int FRAME_BITS  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int INVERT_EVEN = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [7:0]                      in_alaw,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            en,
  input  logic                            clr_underrun,
  output logic                            pcm_sclk,
  output logic                            pcm_fsync,
  output logic                            pcm_dout,
  output logic                            underrun,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int DIV_W = $clog2(CLK_DIV);
  // One extra bit so the "data bits" limit of 8 is representable even when
  // FRAME_BITS is exactly 8.
  localparam int BIT_W = $clog2(FRAME_BITS + 1);

  localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(CLK_DIV / 2);
  localparam logic [BIT_W-1:0] BIT_MAX   = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] DATA_BITS = BIT_W'(8);
  localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(FIFO_DEPTH);
  localparam logic [7:0]       INV_MASK  = (INVERT_EVEN != 0) ? 8'h55 : 8'h00;
  localparam logic [7:0]       IDLE_CODE = 8'hD5;

  typedef enum logic {IDLE, RUN} state_e;

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]        shreg_q, shreg_d;
  logic              sclk_q, sclk_d;
  logic              fsync_q, fsync_d;
  logic              dout_q, dout_d;
  logic              underrun_q, underrun_d;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  count_q, count_d;

  logic push, pop, fifo_empty, tick, boundary, frame_start;

  assign in_ready   = (count_q != FULL_LVL);
  assign fifo_level = count_q;
  assign pcm_sclk   = sclk_q;
  assign pcm_fsync  = fsync_q;
  assign pcm_dout   = dout_q;
  assign underrun   = underrun_q;

  always_comb begin
    push        = in_valid && in_ready;
    fifo_empty  = (count_q == '0);
    tick        = (state_q == RUN) && (div_cnt_q == DIV_MAX);
    boundary    = tick && (bit_cnt_q == BIT_MAX);
    // A frame starts either from IDLE or straight at a boundary, so
    // back-to-back frames have no gap clock.
    frame_start = en && ((state_q == IDLE) || boundary);
    // Emptiness is judged on registered state: a code pushed in this very
    // cycle is not visible to a frame starting now.
    pop         = frame_start && !fifo_empty;

    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    underrun_d = underrun_q;

    if (frame_start) begin
      state_d   = RUN;
      div_cnt_d = '0;
      bit_cnt_d = '0;
      shreg_d   = fifo_empty ? IDLE_CODE : (mem_q[rd_ptr_q] ^ INV_MASK);
    end else if (boundary) begin
      state_d   = IDLE;
      div_cnt_d = '0;
      bit_cnt_d = '0;
    end else if (state_q == RUN) begin
      if (tick) begin
        div_cnt_d = '0;
        bit_cnt_d = bit_cnt_q + 1'b1;
        shreg_d   = {shreg_q[6:0], 1'b0};
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
    end

    // Setting wins over a coincident clear.
    if (frame_start && fifo_empty) begin
      underrun_d = 1'b1;
    end else if (clr_underrun) begin
      underrun_d = 1'b0;
    end

    // Serial outputs are decoded from next-state values so the registered
    // pins line up with the counters they describe.
    sclk_d  = (state_d == RUN) && (div_cnt_d < DIV_HALF);
    fsync_d = (state_d == RUN) && (bit_cnt_d == '0);
    dout_d  = (state_d == RUN) && (bit_cnt_d < DATA_BITS) && shreg_d[7];

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Control, counters, shift register and registered serial outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      sclk_q     <= 1'b0;
      fsync_q    <= 1'b0;
      dout_q     <= 1'b0;
      underrun_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      sclk_q     <= sclk_d;
      fsync_q    <= fsync_d;
      dout_q     <= dout_d;
      underrun_q <= underrun_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_alaw;
    end
  end

endmodule

// File: tb/tb_alaw_pcm_serializer.sv
// tb_alaw_pcm_serializer
//
// Directed bench for alaw_pcm_serializer with CLK_DIV=4, FRAME_BITS=10,
// FIFO_DEPTH=4, INVERT_EVEN=1. Inputs change just after each falling edge
// and outputs are sampled on falling edges, half a cycle from the active edge.
module tb_alaw_pcm_serializer;

  localparam int CLK_DIV    = 4;
  localparam int FRAME_BITS = 10;
  localparam int FIFO_DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] in_alaw;
  logic       in_valid;
  logic       in_ready;
  logic       en;
  logic       clr_underrun;
  logic       pcm_sclk;
  logic       pcm_fsync;
  logic       pcm_dout;
  logic       underrun;
  logic [2:0] fifo_level;

  int errors = 0;
  int checks = 0;

  alaw_pcm_serializer #(
    .CLK_DIV(CLK_DIV),
    .FRAME_BITS(FRAME_BITS),
    .FIFO_DEPTH(FIFO_DEPTH),
    .INVERT_EVEN(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_alaw(in_alaw),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .en(en),
    .clr_underrun(clr_underrun),
    .pcm_sclk(pcm_sclk),
    .pcm_fsync(pcm_fsync),
    .pcm_dout(pcm_dout),
    .underrun(underrun),
    .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] alaw;
    logic       valid;
    logic [2:0] exp_level;
    logic       exp_ready;
  } vec_t;

  vec_t vecs [6];

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs and advance to the next sampling point.
  task automatic applyStimulus(input logic valid, input logic [7:0] code,
                               input logic run, input logic clr);
    in_valid     = valid;
    in_alaw      = code;
    en           = run;
    clr_underrun = clr;
    @(negedge clk);
  endtask

  task automatic checkIdlePins(input string name);
    checkOutput({name, " sclk"},  pcm_sclk,  0);
    checkOutput({name, " fsync"}, pcm_fsync, 0);
    checkOutput({name, " dout"},  pcm_dout,  0);
  endtask

  task automatic pulseReset();
    in_valid = 1'b0; en = 1'b0; clr_underrun = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Entered at the sample right after a frame-start edge; checks every clock
  // of the frame and returns at the sample right after the closing boundary.
  // en is dropped at the start of bit dropBit (-1 keeps it high).
  task automatic runFrame(input string name, input logic [7:0] code, input int dropBit);
    logic expBit;
    for (int b = 0; b < FRAME_BITS; b++) begin
      expBit = (b < 8) ? code[7-b] : 1'b0;
      for (int p = 0; p < CLK_DIV; p++) begin
        checkOutput($sformatf("%s b%0d p%0d dout", name, b, p), pcm_dout, expBit);
        checkOutput($sformatf("%s b%0d p%0d sclk", name, b, p), pcm_sclk, (p < CLK_DIV/2) ? 1 : 0);
        checkOutput($sformatf("%s b%0d p%0d fsync", name, b, p), pcm_fsync, (b == 0) ? 1 : 0);
        if (b == dropBit && p == 0) en = 1'b0;
        @(negedge clk);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_alaw = 8'h00; en = 1'b0; clr_underrun = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset state.
    checkIdlePins("reset");
    checkOutput("reset underrun", underrun, 0);
    checkOutput("reset in_ready", in_ready, 1);
    checkOutput("reset level", fifo_level, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fill the FIFO with en low; the fifth code must be held off.
    vecs[0] = '{8'hA1, 1'b1, 3'd1, 1'b1};
    vecs[1] = '{8'hB2, 1'b1, 3'd2, 1'b1};
    vecs[2] = '{8'hC3, 1'b1, 3'd3, 1'b1};
    vecs[3] = '{8'hD4, 1'b1, 3'd4, 1'b0};
    vecs[4] = '{8'hE5, 1'b1, 3'd4, 1'b0};
    vecs[5] = '{8'hE5, 1'b0, 3'd4, 1'b0};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].alaw, 1'b0, 1'b0);
      checkOutput($sformatf("fill%0d level", i), fifo_level, vecs[i].exp_level);
      checkOutput($sformatf("fill%0d ready", i), in_ready, vecs[i].exp_ready);
      checkOutput($sformatf("fill%0d sclk", i), pcm_sclk, 0);
    end

    // First pop frees a slot the following cycle; the held code then enters.
    applyStimulus(1'b1, 8'hE5, 1'b1, 1'b0);
    checkOutput("pop level", fifo_level, 3);
    checkOutput("pop ready", in_ready, 1);
    checkOutput("pop fsync", pcm_fsync, 1);
    checkOutput("pop dout", pcm_dout, 1);            // A1^55 = F4
    applyStimulus(1'b1, 8'hE5, 1'b0, 1'b0);
    checkOutput("refill level", fifo_level, 4);
    checkOutput("refill ready", in_ready, 0);
    in_valid = 1'b0;
    for (int i = 0; i < 39; i++) @(negedge clk);
    checkIdlePins("after fill frame");
    checkOutput("after fill frame level", fifo_level, 4);

    // Basic frame: code 00 goes out as 55 then two padding zeros.
    pulseReset();
    applyStimulus(1'b1, 8'h00, 1'b0, 1'b0);
    checkOutput("basic push level", fifo_level, 1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("basic pop level", fifo_level, 0);
    runFrame("basic", 8'h55, 0);
    checkIdlePins("basic end");
    checkOutput("basic underrun", underrun, 0);

    // Underrun: empty FIFO sends the idle code raw.
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("underrun set", underrun, 1);
    runFrame("underrun", 8'hD5, 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("underrun cleared", underrun, 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    checkOutput("underrun set beats clear", underrun, 1);
    clr_underrun = 1'b0;
    runFrame("underrun2", 8'hD5, 0);
    checkOutput("underrun still set", underrun, 1);

    // Back-to-back frames, then stop mid-frame, then restart.
    pulseReset();
    applyStimulus(1'b1, 8'h80, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
    checkOutput("b2b level", fifo_level, 3);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    runFrame("b2b first", 8'hD5, -1);
    runFrame("b2b second", 8'hAA, 3);
    checkIdlePins("stop end");
    checkOutput("stop level", fifo_level, 1);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput($sformatf("stopped%0d sclk", i), pcm_sclk, 0);
    end
    checkOutput("stopped level", fifo_level, 1);
    checkOutput("stopped underrun", underrun, 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("restart fsync", pcm_fsync, 1);
    checkOutput("restart dout", pcm_dout, 0);        // 11^55 = 44
    checkOutput("restart level", fifo_level, 0);
    checkOutput("restart underrun", underrun, 0);

    // Asynchronous reset in the middle of a frame.
    @(negedge clk);
    checkOutput("pre-reset sclk", pcm_sclk, 1);
    #2 rst_n = 1'b0;
    #1;
    checkIdlePins("async reset");
    checkOutput("async reset ready", in_ready, 1);
    checkOutput("async reset level", fifo_level, 0);
    checkOutput("async reset underrun", underrun, 0);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
